store_write_buffer: RTL and testbench

- Posted-store buffer between the CPU's MEM stage and the data memory (`dm`).
- Stores are accepted in one cycle and queued in a small FIFO, then drained to memory one word at a time through a write handshake.
- Loads in MEM are checked against the queued stores, and the youngest matching data is forwarded so read-after-write order is preserved.
- A load miss owns the memory port for its cycle; the buffer does not start a drain write in that cycle.

---
 rtl/store_write_buffer_if.sv | 26 ++
 rtl/store_write_buffer.sv | 82 ++++++++
 tb/tb_store_write_buffer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/store_write_buffer_if.sv
// store_write_buffer_if: CPU store/load port plus drain-write port of the posted-store buffer.
interface store_write_buffer_if #(parameter int DEPTH = 4, parameter int AW = 7, parameter int DW = 32);
  logic                    st_valid;
  logic [AW-1:0]           st_addr;
  logic [DW-1:0]           st_data;
  logic                    st_ready;
  logic                    stall;
  logic                    ld_valid;
  logic [AW-1:0]           ld_addr;
  logic                    ld_hit;
  logic [DW-1:0]           ld_data;
  logic                    mem_wr;
  logic [AW-1:0]           mem_addr;
  logic [DW-1:0]           mem_wdata;
  logic                    mem_ack;
  logic [$clog2(DEPTH):0]  count;
  logic                    empty;
  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ack,
    input  st_ready, stall, ld_hit, ld_data, mem_wr, mem_addr, mem_wdata, count, empty
  );
  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ack,
    output st_ready, stall, ld_hit, ld_data, mem_wr, mem_addr, mem_wdata, count, empty
  );
endinterface

// File: rtl/store_write_buffer.sv
// store_write_buffer: posted-store FIFO with youngest-match load forwarding and a drain FSM.
// Define WBUF_COALESCE_EN to merge stores into an existing entry with the same address.
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 7,
  parameter int DW    = 32
) (
  input logic               clk,
  input logic               rst,
  store_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {IDLE, ISSUE} state_t;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, co_idx;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic          full, co_hit, push, coal, pop, ld_miss;
  // Entries are scanned oldest to youngest so the last match wins.
  always_comb begin
    bus.ld_hit  = 1'b0;
    bus.ld_data = '0;
    co_hit      = 1'b0;
    co_idx      = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q && addr_q[head_q + PW'(i)] == bus.ld_addr) begin
        bus.ld_hit  = 1'b1;
        bus.ld_data = data_q[head_q + PW'(i)];
      end
`ifdef WBUF_COALESCE_EN
      if (CW'(i) < count_q && addr_q[head_q + PW'(i)] == bus.st_addr && !(i == 0 && state_q == ISSUE)) begin
        co_hit = 1'b1;
        co_idx = head_q + PW'(i);
      end
`endif
    end
  end
  always_comb begin
    full         = count_q == CW'(DEPTH);
    bus.st_ready = ~full | co_hit;
    bus.stall    = bus.st_valid & ~bus.st_ready;
    push         = bus.st_valid & bus.st_ready & ~co_hit;
    coal         = bus.st_valid & co_hit;
    pop          = bus.mem_wr & bus.mem_ack;
    ld_miss      = bus.ld_valid & ~bus.ld_hit;
    head_d       = head_q + PW'(pop);
    tail_d       = tail_q + PW'(push);
    count_d      = count_q + CW'(push) - CW'(pop);
    state_d      = state_q == IDLE ? ((count_q != '0 && !ld_miss) ? ISSUE : IDLE)
                 : !pop ? ISSUE
                 : (count_d != '0 && !ld_miss) ? ISSUE : IDLE;
  end
  assign bus.mem_wr    = state_q == ISSUE;
  assign bus.count     = count_q;
  assign bus.empty     = count_q == '0;
  assign bus.mem_addr  = bus.empty ? '0 : addr_q[head_q];
  assign bus.mem_wdata = bus.empty ? '0 : data_q[head_q];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= IDLE;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end
  // Payload needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= bus.st_addr;
      data_q[tail_q] <= bus.st_data;
    end else if (coal) begin
      data_q[co_idx] <= bus.st_data;
    end
  end
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: directed test-plan scenarios plus random traffic, checked by a queue-based model.
module tb_store_write_buffer;
  localparam int DEPTH = 4;
  typedef struct { logic [6:0] a; logic [31:0] d; } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  ent_t mq[$];
  bit   issuing = 1'b0;
  bit   m_hit, m_ready, miss;
  logic [31:0] m_data;
  int   ci, sz0, peak;
  store_write_buffer_if #(.DEPTH(DEPTH), .AW(7), .DW(32)) bus();
  store_write_buffer #(.DEPTH(DEPTH), .AW(7), .DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic store(input logic [6:0] a, input logic [31:0] d);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    step();
    bus.st_valid = 1'b0;
  endtask
  task automatic drain();
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 50 && bus.empty !== 1'b1; i++) step();
    chk("drain_empty", bus.empty, 1);
    bus.mem_ack = 1'b0;
  endtask
  // Reference model: the queue holds pending stores oldest-first; issuing tracks an outstanding write.
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      issuing = 1'b0;
    end else begin
      sz0 = mq.size();
      m_hit = 1'b0;
      m_data = '0;
      foreach (mq[k]) if (mq[k].a == bus.ld_addr) begin m_hit = 1'b1; m_data = mq[k].d; end
      ci = -1;
`ifdef WBUF_COALESCE_EN
      foreach (mq[k]) if (mq[k].a == bus.st_addr && !(k == 0 && issuing)) ci = k;
`endif
      m_ready = sz0 < DEPTH || ci >= 0;
      chk("st_ready", bus.st_ready, m_ready);
      chk("stall", bus.stall, bus.st_valid & ~m_ready);
      chk("ld_hit", bus.ld_hit, m_hit);
      chk("ld_data", bus.ld_data, m_data);
      chk("mem_wr", bus.mem_wr, issuing);
      chk("count", bus.count, sz0);
      chk("empty", bus.empty, sz0 == 0);
      chk("mem_addr", bus.mem_addr, sz0 ? mq[0].a : 0);
      chk("mem_wdata", bus.mem_wdata, sz0 ? mq[0].d : 0);
      if (issuing && bus.mem_ack && sz0 != 0) begin
        chk("drain_addr", bus.mem_addr, mq[0].a);
        chk("drain_data", bus.mem_wdata, mq[0].d);
      end
      if (bus.st_valid && m_ready) begin
        if (ci >= 0) mq[ci].d = bus.st_data;
        else mq.push_back('{a: bus.st_addr, d: bus.st_data});
      end
      if (issuing && bus.mem_ack && mq.size() != 0) void'(mq.pop_front());
      miss = bus.ld_valid && !m_hit;
      issuing = issuing ? (bus.mem_ack ? (mq.size() != 0 && !miss) : 1'b1) : (sz0 != 0 && !miss);
    end
  end
  initial begin
    bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.mem_ack = 1'b0;
    repeat (3) step();
    chk("rst_mem_wr", bus.mem_wr, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_st_ready", bus.st_ready, 1);
    chk("rst_stall", bus.stall, 0);
    chk("rst_ld_hit", bus.ld_hit, 0);
    chk("rst_ld_data", bus.ld_data, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    rst = 1'b0;
    step();
    // three stores drained back-to-back
    bus.mem_ack = 1'b1;
    peak = 0;
    store(7'd3, 32'hD3); if (bus.count > peak) peak = bus.count;
    store(7'd5, 32'hD5); if (bus.count > peak) peak = bus.count;
    store(7'd7, 32'hD7); if (bus.count > peak) peak = bus.count;
    drain();
    chk("t1_peak_in_range", peak >= 2 && peak <= 3, 1);
    // full buffer back-pressure
    for (int i = 0; i < 4; i++) store(7'(10 + i), 32'h100 + i);
    chk("t2_count_full", bus.count, 4);
    bus.st_valid = 1'b1; bus.st_addr = 7'd14; bus.st_data = 32'h114;
    #1;
    chk("t2_st_ready", bus.st_ready, 0);
    chk("t2_stall", bus.stall, 1);
    chk("t2_head_addr", bus.mem_addr, 10);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("t2_count_after_pop", bus.count, 3);
    chk("t2_ready_after_pop", bus.st_ready, 1);
    step();
    bus.st_valid = 1'b0;
    chk("t2_count_refill", bus.count, 4);
    chk("t2_new_head", bus.mem_addr, 11);
    drain();
    // duplicate address forwarding
    store(7'd9, 32'hAAAA);
    store(7'd9, 32'hBBBB);
    bus.ld_valid = 1'b1; bus.ld_addr = 7'd9;
    #1;
    chk("t3_ld_hit", bus.ld_hit, 1);
    chk("t3_ld_data", bus.ld_data, 32'hBBBB);
`ifdef WBUF_COALESCE_EN
    chk("t3_count", bus.count, 1);
`else
    chk("t3_count", bus.count, 2);
`endif
    bus.ld_valid = 1'b0;
    drain();
    // load miss holds off the drain
    bus.ld_valid = 1'b1; bus.ld_addr = 7'd100;
    store(7'd20, 32'h2020);
    chk("t4_hold0", bus.mem_wr, 0);
    step();
    chk("t4_hold1", bus.mem_wr, 0);
    step();
    chk("t4_hold2", bus.mem_wr, 0);
    bus.ld_valid = 1'b0;
    step();
    chk("t4_issue", bus.mem_wr, 1);
    drain();
    // stalled write keeps address/data stable
    store(7'd4, 32'h4444);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t5_mem_wr", bus.mem_wr, 1);
      chk("t5_mem_addr", bus.mem_addr, 4);
      chk("t5_mem_wdata", bus.mem_wdata, 32'h4444);
      step();
    end
    store(7'd50, 32'h5050);
    store(7'd51, 32'h5151);
    chk("t6_count_pre", bus.count, 3);
    // asynchronous reset mid-write
    rst = 1'b1;
    #1;
    chk("t6_mem_wr", bus.mem_wr, 0);
    chk("t6_count", bus.count, 0);
    step();
    rst = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_addr = 7'd4;
    #1;
    chk("t6_ld_hit", bus.ld_hit, 0);
    chk("t6_ld_data", bus.ld_data, 0);
    bus.ld_valid = 1'b0;
    step();
    // random traffic
    for (int i = 0; i < 600; i++) begin
      bus.st_valid = $urandom_range(0, 1);
      bus.st_addr  = 7'($urandom_range(0, 7));
      bus.st_data  = $urandom;
      bus.ld_valid = ($urandom_range(0, 9) < 4);
      bus.ld_addr  = 7'($urandom_range(0, 7));
      bus.mem_ack  = ($urandom_range(0, 9) < 6);
      step();
    end
    bus.st_valid = 1'b0;
    bus.ld_valid = 1'b0;
    drain();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
